fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one request at a time to instruction memory and
// holds each fetched instruction for decode, with redirect handling and a fetch timeout.
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [ILEN-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            fault,
  output logic [1:0]      fault_cause
);

  localparam int            CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);

  typedef enum logic [1:0] {START, FETCH, HOLD, FAULT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            drop;
  logic [CW-1:0]   wait_cnt;

  logic            misaligned;
  logic [CW-1:0]   cnt_inc;
  logic            timed_out;

  assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
  assign cnt_inc    = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
  assign timed_out  = (TIMEOUT > 0) && (cnt_inc >= TMO);

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= START;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      drop        <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        START: begin
          if (misaligned) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_cause <= 2'b01;
          end else begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            wait_cnt <= '0;
            if (redirect) begin
              pc       <= redirect_pc;
              mem_addr <= redirect_pc;
            end else begin
              mem_addr <= pc;
            end
          end
        end

        // A redirect that arrives before the ack cannot cancel the bus request,
        // so the stale response is swallowed via drop before refetching.
        FETCH: begin
          if (misaligned) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_cause <= 2'b01;
            drop        <= 1'b0;
            if (mem_ack) mem_req <= 1'b0;
          end else if (mem_ack) begin
            wait_cnt <= '0;
            if (redirect) begin
              pc       <= redirect_pc;
              mem_addr <= redirect_pc;
              drop     <= 1'b0;
            end else if (drop) begin
              drop     <= 1'b0;
              mem_addr <= pc;
            end else begin
              instr       <= mem_rdata;
              instr_pc    <= mem_addr;
              pc          <= pc + XLEN'(4);
              mem_req     <= 1'b0;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else begin
            wait_cnt <= cnt_inc;
            if (redirect) begin
              pc   <= redirect_pc;
              drop <= 1'b1;
            end else if (timed_out) begin
              state       <= FAULT;
              fault       <= 1'b1;
              fault_cause <= 2'b10;
              mem_req     <= 1'b0;
            end
          end
        end

        HOLD: begin
          if (misaligned) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_cause <= 2'b01;
            instr_valid <= 1'b0;
          end else if (redirect) begin
            pc          <= redirect_pc;
            mem_addr    <= redirect_pc;
            mem_req     <= 1'b1;
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
            state       <= FETCH;
          end else if (instr_ready) begin
            mem_addr    <= pc;
            mem_req     <= 1'b1;
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
            state       <= FETCH;
          end
        end

        FAULT: begin
          if (mem_req && mem_ack) mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

  localparam int TMO_A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mem_req, mem_ack = 1'b0, redirect = 1'b0, instr_valid, instr_ready = 1'b1, fault;
  logic [63:0] mem_addr, redirect_pc = '0, instr_pc;
  logic [31:0] mem_rdata = '0, instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  fault_cause;

  logic        b_rst = 1'b1, b_req, b_ack = 1'b0, b_valid, b_fault;
  logic [31:0] b_addr, b_ipc, b_rdata = '0, b_instr;
  logic [6:0]  b_opcode;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [1:0]  b_cause;

  fetch_unit #(.XLEN(64), .ILEN(32), .RESET_PC(64'h0), .TIMEOUT(TMO_A)) dut_a (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .fault(fault), .fault_cause(fault_cause)
  );

  fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'hFFFF_FFFC), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(b_rst), .mem_req(b_req), .mem_addr(b_addr), .mem_ack(b_ack),
    .mem_rdata(b_rdata), .redirect(1'b0), .redirect_pc(32'h0),
    .instr_valid(b_valid), .instr_ready(1'b1), .instr(b_instr), .instr_pc(b_ipc),
    .opcode(b_opcode), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .fault(b_fault), .fault_cause(b_cause)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[23:0], 8'h00} ^ 32'h0051_8193;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [63:0] target);
    redirect    = en;
    redirect_pc = target;
  endtask

  task automatic doReset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Memory responder: acks after ack_delay idle cycles of a request.
  int ack_delay = 0;
  bit resp_on = 1'b1;
  bit ack_force = 1'b0;
  int age = 0;
  bit prev_req = 1'b0;
  always @(negedge clk) begin
    if (!mem_req || mem_ack || !prev_req) age = 0;
    else age = age + 1;
    prev_req  = mem_req;
    mem_ack   = ack_force || (resp_on && mem_req && age >= ack_delay);
    mem_rdata = mem_word(mem_addr);
  end

  bit b_ack_on = 1'b1;
  always @(negedge clk) begin
    b_ack   = b_ack_on && b_req;
    b_rdata = mem_word({32'h0, b_addr});
  end

  // Reference model: one outstanding request, one held instruction, sticky fault.
  bit          m_boot = 1'b1, m_hold = 1'b0, m_fault = 1'b0, m_req = 1'b0, m_discard = 1'b0;
  logic [63:0] m_pc = '0, m_addr = '0, m_ipc = '0;
  logic [31:0] m_instr = '0;
  logic [1:0]  m_cause = '0;
  int          m_waits = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_boot = 1'b1; m_hold = 1'b0; m_fault = 1'b0; m_req = 1'b0; m_discard = 1'b0;
      m_pc = '0; m_addr = '0; m_ipc = '0; m_instr = '0; m_cause = 2'b00; m_waits = 0;
    end else if (m_fault) begin
      if (m_req && mem_ack) m_req = 1'b0;
    end else if (redirect && redirect_pc[1:0] != 2'b00) begin
      m_fault = 1'b1; m_cause = 2'b01; m_hold = 1'b0; m_boot = 1'b0;
      if (m_req && mem_ack) m_req = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      if (redirect) m_pc = redirect_pc;
      m_req = 1'b1; m_addr = m_pc; m_waits = 0;
    end else if (m_hold) begin
      if (redirect || instr_ready) begin
        if (redirect) m_pc = redirect_pc;
        m_hold = 1'b0; m_req = 1'b1; m_addr = m_pc; m_waits = 0;
      end
    end else if (mem_ack) begin
      m_waits = 0;
      if (redirect) begin
        m_pc = redirect_pc; m_addr = m_pc; m_discard = 1'b0;
      end else if (m_discard) begin
        m_discard = 1'b0; m_addr = m_pc;
      end else begin
        m_instr = mem_word(m_addr); m_ipc = m_addr; m_pc = m_pc + 64'd4;
        m_hold = 1'b1; m_req = 1'b0;
      end
    end else begin
      m_waits++;
      if (redirect) begin
        m_pc = redirect_pc; m_discard = 1'b1;
      end else if (m_waits >= TMO_A) begin
        m_fault = 1'b1; m_cause = 2'b10; m_req = 1'b0;
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("mdl_mem_req", 64'(mem_req), 64'(m_req));
      checkOutput("mdl_mem_addr", mem_addr, m_addr);
      checkOutput("mdl_instr_valid", 64'(instr_valid), 64'(m_hold));
      checkOutput("mdl_instr", 64'(instr), 64'(m_instr));
      checkOutput("mdl_instr_pc", instr_pc, m_ipc);
      checkOutput("mdl_fields", 64'({opcode, rd, rs1, rs2}),
                  64'({m_instr[6:0], m_instr[11:7], m_instr[19:15], m_instr[24:20]}));
      checkOutput("mdl_fault", 64'({fault, fault_cause}), 64'({m_fault, m_cause}));
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] addrs [3];
    logic [63:0] newaddr, ipc;
    logic [31:0] iw, baddr [2];
    int n, vcount, stable, vidx, bad, reqs;
    bit found;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset_mem_req", 64'(mem_req), 64'h0);
    checkOutput("reset_mem_addr", mem_addr, 64'h0);
    checkOutput("reset_valid", 64'(instr_valid), 64'h0);
    checkOutput("reset_fault", 64'({fault, fault_cause}), 64'h0);

    // Zero-wait memory, decode always ready
    rst = 1'b0;
    checkOutput("start_no_req", 64'(mem_req), 64'h0);
    n = 0; vcount = 0;
    for (int i = 0; i < 3; i++) addrs[i] = '1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (mem_req && n < 3) begin addrs[n] = mem_addr; n++; end
      if (instr_valid) vcount++;
      if (i == 2) begin
        checkOutput("first_valid", 64'(instr_valid), 64'h1);
        checkOutput("first_instr_pc", instr_pc, 64'h0);
        checkOutput("first_instr", 64'(instr), 64'h0051_8193);
        checkOutput("first_opcode", 64'(opcode), 64'h13);
        checkOutput("first_rd", 64'(rd), 64'h3);
        checkOutput("first_rs1", 64'(rs1), 64'h3);
        checkOutput("first_rs2", 64'(rs2), 64'h5);
      end
    end
    checkOutput("seq_addr0", addrs[0], 64'h0);
    checkOutput("seq_addr1", addrs[1], 64'h4);
    checkOutput("seq_addr2", addrs[2], 64'h8);
    checkOutput("valid_every_2nd", 64'(vcount), 64'd3);

    // Ack delayed by three cycles
    ack_delay = 3;
    doReset();
    stable = 0; vidx = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 64'h0) stable++;
      if (instr_valid && vidx < 0) vidx = i;
    end
    checkOutput("delay_addr_stable", 64'(stable), 64'd4);
    checkOutput("delay_valid_cycle", 64'(vidx), 64'd5);

    // Redirect during an unacked fetch of 0x8
    ack_delay = 2;
    doReset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 64'h8) found = 1'b1;
    end
    checkOutput("reach_0x8", 64'(found), 64'h1);
    applyStimulus(1'b1, 64'h100);
    @(negedge clk) applyStimulus(1'b0, 64'h0);
    bad = 0; newaddr = '1; found = 1'b0; ipc = '1; iw = '1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (instr_valid && instr_pc == 64'h8) bad++;
      if (mem_req && mem_addr != 64'h8 && newaddr == '1) newaddr = mem_addr;
      if (instr_valid) begin found = 1'b1; ipc = instr_pc; iw = instr; end
    end
    checkOutput("drop_0x8_never_valid", 64'(bad), 64'h0);
    checkOutput("redirect_next_addr", newaddr, 64'h100);
    checkOutput("redirect_instr_pc", ipc, 64'h100);
    checkOutput("redirect_instr", 64'(iw), 64'(mem_word(64'h100)));

    // Two redirects while the old request is still pending: last one wins
    ack_delay = 3;
    @(negedge clk);
    checkOutput("after_redirect_seq", mem_addr, 64'h104);
    applyStimulus(1'b1, 64'h200);
    @(negedge clk) applyStimulus(1'b1, 64'h300);
    @(negedge clk) applyStimulus(1'b0, 64'h0);
    found = 1'b0; ipc = '1;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) begin found = 1'b1; ipc = instr_pc; end
    end
    checkOutput("last_redirect_wins", ipc, 64'h300);

    // Redirect in the same cycle as the ack
    ack_delay = 0;
    @(negedge clk);
    checkOutput("zero_wait_addr", mem_addr, 64'h304);
    applyStimulus(1'b1, 64'h400);
    @(negedge clk) applyStimulus(1'b0, 64'h0);
    checkOutput("ack_redirect_addr", mem_addr, 64'h400);
    checkOutput("ack_redirect_req", 64'(mem_req), 64'h1);
    @(negedge clk);
    checkOutput("ack_redirect_valid", 64'({instr_valid, instr_pc}), {1'b1, 64'h400});

    // Misaligned redirect while holding
    applyStimulus(1'b1, 64'h102);
    @(negedge clk) applyStimulus(1'b0, 64'h0);
    checkOutput("misalign_fault", 64'({fault, fault_cause}), 64'b101);
    checkOutput("misalign_req", 64'(mem_req), 64'h0);
    checkOutput("misalign_valid", 64'(instr_valid), 64'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      applyStimulus(i[0], 64'h200);
      ack_force = i[1];
    end
    @(negedge clk);
    applyStimulus(1'b0, 64'h0);
    ack_force = 1'b0;
    checkOutput("fault_sticky", 64'({fault, fault_cause, mem_req, instr_valid}), 64'b10100);

    // Reset mid-request with a stray ack, then timeout
    resp_on = 1'b0;
    doReset();
    @(negedge clk);
    checkOutput("pending_req", 64'(mem_req), 64'h1);
    rst = 1'b1; ack_force = 1'b1;
    @(negedge clk) rst = 1'b0;
    checkOutput("reset_mid_request", 64'({mem_req, mem_addr}), 64'h0);
    @(posedge clk);
    #1 ack_force = 1'b0;
    reqs = 0; found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput("stray_ack_ignored", 64'({mem_req, instr_valid}), 64'b10);
      if (mem_req) reqs++;
      if (fault) found = 1'b1;
    end
    checkOutput("timeout_seen", 64'(found), 64'h1);
    checkOutput("timeout_wait_cycles", 64'(reqs), 64'd4);
    checkOutput("timeout_cause", 64'({fault_cause, mem_req, instr_valid}), 64'b1000);

    resp_on = 1'b1;
    doReset();
    @(negedge clk);
    checkOutput("restart_addr", 64'({mem_req, mem_addr}), {1'b1, 64'h0});
    @(negedge clk);
    checkOutput("restart_valid", 64'({instr_valid, fault, instr_pc}), {2'b10, 64'h0});

    // Misaligned redirect with a request outstanding
    ack_delay = 2;
    @(negedge clk);
    applyStimulus(1'b1, 64'h6);
    @(negedge clk) applyStimulus(1'b0, 64'h0);
    checkOutput("misalign_fetch_pending", 64'({fault, fault_cause, mem_req}), 64'b1011);
    repeat (2) @(negedge clk);
    checkOutput("misalign_fetch_release", 64'({fault, mem_req}), 64'b10);

    // 32-bit instance: PC wrap and disabled timeout
    b_rst = 1'b0;
    n = 0; baddr[0] = '1; baddr[1] = '1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (b_req && n < 2) begin baddr[n] = b_addr; n++; end
      if (i == 2) begin
        checkOutput("b_first_ipc", 64'({b_valid, b_ipc}), {1'b1, 32'hFFFF_FFFC});
        checkOutput("b_first_instr", 64'(b_instr), 64'hFFAE_7D93);
        checkOutput("b_fields", 64'({b_opcode, b_rd, b_rs1, b_rs2}),
                    64'({7'h13, 5'd27, 5'd28, 5'd26}));
      end
      if (i == 4) begin
        checkOutput("b_wrap_ipc", 64'({b_valid, b_ipc}), {1'b1, 32'h0});
        b_ack_on = 1'b0;
      end
    end
    checkOutput("b_addr0", 64'(baddr[0]), 64'hFFFF_FFFC);
    checkOutput("b_addr1_wrap", 64'(baddr[1]), 64'h0);
    repeat (300) @(negedge clk);
    checkOutput("b_no_timeout", 64'({b_fault, b_cause, b_req, b_valid}), 64'b00010);
    checkOutput("b_held_addr", 64'(b_addr), 64'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
